// File: rtl/moore_seq_detector.sv
// moore_seq_detector: Moore FSM serial pattern detector with a KMP next-state table and an optional saturating match counter (MOORE_SEQ_DETECTOR_COUNT_EN).
module moore_seq_detector #(
    parameter int PATTERN_LEN = 3,
    parameter logic [PATTERN_LEN-1:0] PATTERN = 3'b101,
    parameter int OVERLAP = 1,
    parameter int CNT_WIDTH = 8
) (
    input  logic                               clock,
    input  logic                               reset_n,
    input  logic                               enable,
    input  logic                               a,
    input  logic                               clear,
    output logic                               y,
    output logic [$clog2(PATTERN_LEN+1)-1:0]   state,
    output logic [CNT_WIDTH-1:0]               match_count
);
    localparam int SW = $clog2(PATTERN_LEN + 1);
    localparam logic [SW-1:0] FULL = SW'(PATTERN_LEN);

    // Longest pattern prefix that is a suffix of (matched prefix of length s, bit b);
    // the full-match state without overlap restarts from an empty history.
    function automatic int next_fn(input int s, input int b);
        int p, sv, r;
        p = int'(PATTERN);
        sv = ((p >> (PATTERN_LEN - s)) << 1) | b;
        r = 0;
        if (s == PATTERN_LEN && OVERLAP == 0)
            return (b == ((p >> (PATTERN_LEN - 1)) & 1)) ? 1 : 0;
        for (int k = 1; k <= PATTERN_LEN; k++)
            if (k <= s + 1 && (sv % (1 << k)) == (p >> (PATTERN_LEN - k)))
                r = k;
        return r;
    endfunction

    logic [SW-1:0] nxt_tbl [PATTERN_LEN+1][2];

    genvar s, b;
    for (s = 0; s <= PATTERN_LEN; s++) begin : g_s
        for (b = 0; b < 2; b++) begin : g_b
            localparam logic [SW-1:0] NS = SW'(next_fn(s, b));
            assign nxt_tbl[s][b] = NS;
        end
    end

    logic [SW-1:0] state_q, state_d;

    // Next state from the elaborated table, held when the input bit is not qualified
    always_comb state_d = enable ? nxt_tbl[state_q][a] : state_q;

    // State register
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) state_q <= '0;
        else          state_q <= state_d;

    assign state = state_q;
    assign y     = (state_q == FULL);

`ifdef MOORE_SEQ_DETECTOR_COUNT_EN
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    // Clear wins over a completing match; the count sticks at all-ones
    always_comb cnt_d = clear ? '0 :
                        (enable && state_d == FULL && cnt_q != '1) ? cnt_q + CNT_WIDTH'(1) : cnt_q;

    // Match counter register
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;

    assign match_count = cnt_q;
`else
    logic unused_clear;
    assign unused_clear = clear;
    assign match_count  = '0;
`endif
endmodule

// File: doc/moore_seq_detector.md
MOORE_SEQ_DETECTOR -- requirements
Module: moore_seq_detector

Interface
REQ-001 SHALL have parameter PATTERN_LEN, default 3, meaning pattern length L in bits, legal range 2..8.
REQ-002 SHALL have parameter PATTERN, default 3'b101, meaning the target sequence; PATTERN[L-1] is the first bit received.
REQ-003 SHALL have parameter OVERLAP, default 1, meaning 1 = overlapping matches and 0 = non-overlapping matches.
REQ-004 SHALL have parameter CNT_WIDTH, default 8, meaning the match counter width, legal range 1..16.
REQ-005 SHALL have clock  input  1  sole clock; all state changes on its rising edge.
REQ-006 SHALL have reset_n  input  1  reset, asynchronous and active-low.
REQ-007 SHALL have enable  input  1  qualifies a; when low, input a is ignored for that edge.
REQ-008 SHALL have a  input  1  serial data bit.
REQ-009 SHALL have clear  input  1  synchronous clear of match_count only.
REQ-010 SHALL have y  output  1  Moore match flag.
REQ-011 SHALL have state  output  SW = clog2(L+1)  number of pattern bits currently matched (0..L).
REQ-012 SHALL have match_count  output  CNT_WIDTH  saturating count of completed matches.

Function
REQ-013 SHALL hold state S = length of the longest prefix of PATTERN that equals a suffix of the accepted bit stream, with S limited to 0..L.
REQ-014 SHALL accept bit a on a rising edge only when enable=1; when enable=0, state and match_count SHALL hold.
REQ-015 SHALL compute next state from S<L with accepted bit a as follows: S+1 if a matches the next pattern bit; otherwise the longest prefix that is a suffix of (matched prefix, a), i.e. a KMP fallback.
REQ-016 SHALL, in state L with OVERLAP=1, compute the next state by the KMP fallback from the longest proper border of PATTERN.
REQ-017 SHALL, in state L with OVERLAP=0, go to state 1 if a equals PATTERN[L-1], else to state 0.
REQ-018 SHALL derive the fallback table from parameters at elaboration, with no runtime pattern storage.
REQ-019 SHALL drive y = (state == L), a function of state only (Moore); y asserts the cycle after the final pattern bit is accepted and lasts one cycle unless overlap keeps the FSM in state L.
REQ-020 SHALL increment match_count at each edge where enable=1 and next state == L.
REQ-021 SHALL saturate match_count at 2^CNT_WIDTH-1 with no wrap.
REQ-022 SHALL give clear=1 priority over increment on the same edge; match_count becomes 0 and state is unaffected.
REQ-023 SHALL apply clear regardless of enable.

Reset
REQ-024 SHALL, on reset_n=0, immediately and asynchronously set state=0, y=0 and match_count=0.
REQ-025 SHALL accept the first bit at the first rising edge after reset_n deasserts, provided enable=1.
REQ-026 SHALL, on reset mid-sequence, discard any partial match; the next match needs all L bits again.

Configuration
REQ-027 SHALL use macro MOORE_SEQ_DETECTOR_COUNT_EN to control the match counter.
REQ-028 SHALL, with MOORE_SEQ_DETECTOR_COUNT_EN defined, implement match_count per REQ-020..REQ-023.
REQ-029 SHALL, without MOORE_SEQ_DETECTOR_COUNT_EN, tie match_count to 0, ignore clear, and leave no counter flops; state and y behaviour are unchanged.

Verification
REQ-030 SHALL cover: PATTERN=101, OVERLAP=1, enable=1, a=1,0,1,0,1 -> state 1,2,3,2,3; y high after bits 3 and 5; match_count=2.
REQ-031 SHALL cover: PATTERN=101, OVERLAP=0, a=1,0,1,0,1 -> state 1,2,3,0,1; y high once after bit 3; match_count=1.
REQ-032 SHALL cover: PATTERN=11, L=2, OVERLAP=1, a=1,1,1,1 -> y high for 3 consecutive cycles; match_count=3.
REQ-033 SHALL cover: PATTERN=101 with enable toggling 0/1 every cycle and a toggling -> state changes only on enable=1 edges; a at enable=0 edges has no effect.
REQ-034 SHALL cover: a=1,0 (state=2), then reset_n pulsed low between edges -> state=0 and y=0 immediately; then a=1 -> state=1, no match.
REQ-035 SHALL cover: CNT_WIDTH=2, 5 overlapping matches -> match_count=3 (saturated); then clear=1 with a match completing on the same edge -> match_count=0.
